tick_bcd_counter: RTL and testbench

- Consumes the divided clock produced by the clock divider stage and turns each rising edge into a single-cycle `tick` in the `clk_in` domain.
- Accumulates those ticks in a DIGITS-wide BCD counter with enable, synchronous clear, parallel load and a wrap-carry pulse.
- Sits directly downstream of the divider and directly upstream of display and LED logic.

---
 rtl/tick_bcd_counter_if.sv | 25 ++
 rtl/tick_bcd_counter.sv | 107 ++++++++++
 tb/tb_tick_bcd_counter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_bcd_counter_if.sv
// Signal bundle between the clock divider / control logic and tick_bcd_counter.
// master: the side that drives clk_slow and the counter controls.
// slave : the counter itself, which returns tick, bcd and carry.
interface tick_bcd_counter_if #(
  parameter int DIGITS = 4
);
  logic                  clk_slow;
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  tick;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry;

  modport master (
    output clk_slow, en, clr, load, load_val,
    input  tick, bcd, carry
  );

  modport slave (
    input  clk_slow, en, clr, load, load_val,
    output tick, bcd, carry
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: turns rising edges of the divided clock clk_slow into
// single-cycle ticks in the clk_in domain and counts them in a DIGITS-wide
// BCD counter with enable, synchronous clear, parallel load and wrap carry.
//
// Build option: define TICK_BCD_SYNC_EN to put a two-flop synchronizer on
// clk_slow ahead of the edge detector (needed whenever clk_slow is not a
// registered signal of the clk_in domain). Tick latency is then two clk_in
// edges longer; everything else is identical.
module tick_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  tick_bcd_counter_if.slave bus
);

  logic                  level;
  logic                  prev;
  logic                  rise;
  logic                  tick_p2;
  logic [4*DIGITS-1:0]   bcd_p2;
  logic                  carry_p2;
  logic [4*DIGITS:0]     inc_res;

  // BCD increment: returns {wrap, next_value}. A digit >= 9 that advances
  // rolls to 0 and passes the advance on, so non-BCD digits (10..15) left by
  // a load also roll to 0. wrap is set only if every digit rolled over.
  function automatic logic [4*DIGITS:0] bcd_inc(input logic [4*DIGITS-1:0] val);
    logic [4*DIGITS-1:0] res;
    logic                adv;
    logic [3:0]          d;
    res = val;
    adv = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = val[4*i +: 4];
      if (adv) begin
        if (d >= 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = d + 4'd1;
          adv           = 1'b0;
        end
      end
    end
    return {adv, res};
  endfunction

`ifdef TICK_BCD_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Stage p0/p1: two-flop synchronizer bringing clk_slow into the clk_in domain
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.clk_slow;
      sync_p1 <= sync_p0;
    end
  end

  assign level = sync_p1;
`else
  // clk_slow is already a registered clk_in-domain signal from the divider
  assign level = bus.clk_slow;
`endif

  // prev starts at 0, so a level already high at reset release counts as a rise
  assign rise    = level & ~prev;
  assign inc_res = bcd_inc(bcd_p2);

  // Edge detector history and registered tick; tick ignores en/clr/load
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      prev    <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      prev    <= level;
      tick_p2 <= rise;
    end
  end

  // Stage p2: counter update, priority clr > load > counted rise > hold
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      bcd_p2   <= '0;
      carry_p2 <= 1'b0;
    end else if (bus.clr) begin
      bcd_p2   <= '0;
      carry_p2 <= 1'b0;
    end else if (bus.load) begin
      bcd_p2   <= bus.load_val;
      carry_p2 <= 1'b0;
    end else if (rise && bus.en) begin
      bcd_p2   <= inc_res[4*DIGITS-1:0];
      carry_p2 <= inc_res[4*DIGITS];
    end else begin
      carry_p2 <= 1'b0;
    end
  end

  assign bus.tick  = tick_p2;
  assign bus.bcd   = bcd_p2;
  assign bus.carry = carry_p2;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter (DIGITS = 4, clk_in 10 ns,
// clk_slow 200 ns with ~100 ns high). Each clk_slow edge pushes the expected
// counter state into a queue; it is popped and compared when tick appears.
`timescale 1ns/1ps
module tb_tick_bcd_counter;
  localparam int DIGITS = 4;
`ifdef TICK_BCD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [15:0] bcd;
    logic        carry;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   tick_count  = 0;
  exp_t exp_q[$];

  tick_bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  tick_bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Running count of observed tick cycles
  always @(negedge clk_in) if (bus.tick === 1'b1) tick_count++;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One clk_slow pulse. with_clr asserts clr for exactly the cycle in which
  // the rise is acted upon. lat = negedges from raising clk_slow to tick.
  task automatic slow_edge(input logic [15:0] exp_bcd, input logic exp_carry,
                           input bit with_clr, output int lat);
    exp_t e;
    bit   seen;
    e.bcd   = exp_bcd;
    e.carry = exp_carry;
    exp_q.push_back(e);
    @(negedge clk_in);
    bus.clk_slow = 1'b1;
    if (with_clr && LAT == 0) bus.clr = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk_in);
      bus.clr = 1'b0;
      if (bus.tick === 1'b1) begin
        seen = 1'b1;
        lat  = n;
      end else if (with_clr && n == LAT) begin
        bus.clr = 1'b1;
      end
    end
    e = exp_q.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL tick_timeout: no tick within 10 cycles, required one (exp bcd %h)", e.bcd);
    end else begin
      vectors++;
      if (bus.bcd !== e.bcd) begin
        miscompares++;
        $display("FAIL bcd_at_tick: got %h, required %h", bus.bcd, e.bcd);
      end
      vectors++;
      if (bus.carry !== e.carry) begin
        miscompares++;
        $display("FAIL carry_at_tick: got %b, required %b (bcd %h)", bus.carry, e.carry, e.bcd);
      end
      @(negedge clk_in);
      vectors++;
      if (bus.tick !== 1'b0 || bus.carry !== 1'b0) begin
        miscompares++;
        $display("FAIL pulse_width: tick=%b carry=%b one cycle later, required 0/0", bus.tick, bus.carry);
      end
    end
    repeat (8) @(negedge clk_in);
    bus.clk_slow = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic do_load(input logic [15:0] val);
    @(negedge clk_in);
    bus.load     = 1'b1;
    bus.load_val = val;
    @(negedge clk_in);
    bus.load = 1'b0;
    vectors++;
    if (bus.bcd !== val) begin
      miscompares++;
      $display("FAIL load: got %h, required %h", bus.bcd, val);
    end
  endtask

  task automatic test_reset();
    int lat;
    bus.clk_slow = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    reset        = 1'b0;
    #30 reset = 1'b1;
    #1;
    vectors++;
    if (bus.bcd !== 16'h0000 || bus.tick !== 1'b0 || bus.carry !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: bcd=%h tick=%b carry=%b, required 0000/0/0", bus.bcd, bus.tick, bus.carry);
    end
    bus.en = 1'b1;
    for (int k = 1; k <= 5; k++) slow_edge(to_bcd(k), 1'b0, 1'b0, lat);
    vectors++;
    if (tick_count !== 5 || bus.bcd !== 16'h0005) begin
      miscompares++;
      $display("FAIL five_edges: ticks=%0d bcd=%h, required 5/0005", tick_count, bus.bcd);
    end
  endtask

  task automatic test_latency();
    int lat;
    slow_edge(to_bcd(6), 1'b0, 1'b0, lat);
    vectors++;
    if (lat !== LAT + 1) begin
      miscompares++;
      $display("FAIL latency: tick seen %0d negedges after raise, required %0d", lat, LAT + 1);
    end
  endtask

  task automatic test_load_wrap();
    int lat;
    do_load(16'h9998);
    slow_edge(16'h9999, 1'b0, 1'b0, lat);
    slow_edge(16'h0000, 1'b1, 1'b0, lat);
  endtask

  task automatic test_enable_clr();
    int lat;
    int start;
    slow_edge(16'h0001, 1'b0, 1'b0, lat);
    bus.en = 1'b0;
    start  = tick_count;
    for (int k = 0; k < 3; k++) slow_edge(16'h0001, 1'b0, 1'b0, lat);
    vectors++;
    if (tick_count - start !== 3 || bus.bcd !== 16'h0001) begin
      miscompares++;
      $display("FAIL enable_off: ticks=%0d bcd=%h, required 3/0001", tick_count - start, bus.bcd);
    end
    bus.en = 1'b1;
    slow_edge(16'h0002, 1'b0, 1'b0, lat);
    slow_edge(16'h0000, 1'b0, 1'b1, lat);
  endtask

  task automatic test_non_bcd();
    int lat;
    do_load(16'h000C);
    slow_edge(16'h0010, 1'b0, 1'b0, lat);
    do_load(16'h09F9);
    slow_edge(16'h1000, 1'b0, 1'b0, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    int start;
    do_load(16'h0041);
    slow_edge(16'h0042, 1'b0, 1'b0, lat);
    @(negedge clk_in);
    #1 reset = 1'b0;
    #2;
    vectors++;
    if (bus.bcd !== 16'h0000 || bus.tick !== 1'b0 || bus.carry !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: bcd=%h tick=%b carry=%b, required 0000/0/0", bus.bcd, bus.tick, bus.carry);
    end
    #3 reset = 1'b1;
    start = tick_count;
    slow_edge(16'h0001, 1'b0, 1'b0, lat);
    slow_edge(16'h0002, 1'b0, 1'b0, lat);
    vectors++;
    if (tick_count - start !== 2) begin
      miscompares++;
      $display("FAIL resume_ticks: got %0d, required 2", tick_count - start);
    end
  endtask

  task automatic test_reset_high();
    bit seen;
    int start;
    @(negedge clk_in);
    reset        = 1'b0;
    bus.clk_slow = 1'b1;
    @(negedge clk_in);
    start = tick_count;
    reset = 1'b1;
    seen  = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk_in);
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || bus.bcd !== 16'h0001) begin
      miscompares++;
      $display("FAIL release_high: seen=%b bcd=%h, required 1/0001", seen, bus.bcd);
    end
    repeat (10) @(negedge clk_in);
    bus.clk_slow = 1'b0;
    repeat (10) @(negedge clk_in);
    vectors++;
    if (tick_count - start !== 1) begin
      miscompares++;
      $display("FAIL release_high_count: got %0d ticks, required 1", tick_count - start);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_load_wrap();
    test_enable_clr();
    test_non_bcd();
    test_reset_mid();
    test_reset_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
